register_file: RTL
==================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter N, default 20, data width; SHALL match the ALU operand width.
REQ-002 Parameter REGS, default 16, register count; address width AW = log2(REGS) = 4.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ra1  in  AW  read address, port 1; drives ALU operand A.
REQ-006 ra2  in  AW  read address, port 2; drives ALU operand B.
REQ-007 rd1  out  N  read data, port 1.
REQ-008 rd2  out  N  read data, port 2.
REQ-009 we  in  1  write enable, ALU result writeback.
REQ-010 wa  in  AW  write address.
REQ-011 wd  in  N  write data, the ALU Result.
REQ-012 issue  in  1  an operation targeting issue_rd is dispatched this cycle.
REQ-013 issue_rd  in  AW  destination register of the dispatched operation.
REQ-014 stall  out  1  a source register has a write pending.
REQ-015 z_we  in  1  capture the ALU zero flag.
REQ-016 z_in  in  1  ALU Z output.
REQ-017 z_flag  out  1  registered zero flag.

Function
REQ-018 Reads SHALL be combinational, with zero-cycle latency from ra1/ra2 to rd1/rd2.
REQ-019 Register 0 SHALL always read 20'h00000; writes and issues to address 0 SHALL be ignored.
REQ-020 On a rising edge with we=1 and wa!=0, reg[wa] SHALL take wd; the new value SHALL be visible on the following cycle.
REQ-021 Bypass: when we=1, wa!=0 and wa==raX in the same cycle, rdX SHALL equal wd combinationally.
REQ-022 Scoreboard: pending[REGS] bit vector; on issue=1, stall=0 and issue_rd!=0, pending[issue_rd] SHALL be set at the next edge.
REQ-023 On we=1, pending[wa] SHALL be cleared at the next edge.
REQ-024 Simultaneous issue and we to the same register: pending SHALL remain set, because issue wins (new producer).
REQ-025 stall = (pending[ra1] & ra1!=0 & !(we & wa==ra1)) | the same expression for ra2; combinational.
REQ-026 An issue presented while stall=1 SHALL NOT modify pending.
REQ-027 A write to a register whose pending bit is clear SHALL be accepted normally (no error).
REQ-028 On z_we=1, z_flag SHALL take z_in at the next edge; otherwise z_flag SHALL hold.
REQ-029 No arithmetic is performed; all data paths SHALL be exactly N bits with no truncation or extension.

Reset
REQ-030 When rst=1 at a rising edge, all registers SHALL become 0, pending SHALL become all-zero, and z_flag SHALL become 0.
REQ-031 rst SHALL dominate we, issue and z_we in the same cycle; those inputs SHALL be discarded.
REQ-032 During and after reset, stall SHALL be 0, and rd1/rd2 SHALL read 0 for every address until the first write.

Structure
REQ-033 The shared package SHALL hold N, REGS, AW and the 3-bit ALU opcode enum (ADD=000, SUB=001, MUL=010, DIV=011, AND=100, OR=101, SHL=110, SHR=111), shared with the ALU and decode.
REQ-034 The scoreboard (pending vector, set/clear, stall logic) SHALL be a sub-module named reg_scoreboard; storage, bypass and the Z register stay in register_file.

Verification
REQ-035 Reset check: rst=1 for one cycle, then read all 16 addresses -> every read returns 20'h00000, stall=0, z_flag=0.
REQ-036 Write then read: we=1, wa=3, wd=20'hAAAAA; next cycle ra1=3 -> rd1=20'hAAAAA. In the same cycle, ra2=3 with we=1, wd=20'h55555 -> rd2=20'h55555 via bypass.
REQ-037 Register 0: we=1, wa=0, wd=20'hFFFFF, then ra1=0 -> rd1=20'h00000; issue with issue_rd=0 -> stall stays 0.
REQ-038 Scoreboard:
- issue=1, issue_rd=5; next cycle ra1=5 -> stall=1.
- we=1, wa=5, wd=20'h0000C -> stall=0 in that same cycle and rd1=20'h0000C.
- Following cycle: pending[5]=0.
REQ-039 Collision: pending[7] set; issue_rd=7 and wa=7 in the same cycle -> pending[7] remains 1. An issue while stall=1 -> pending unchanged.
REQ-040 Z flag and reset priority:
- z_we=1, z_in=1 -> z_flag=1 next cycle.
- z_we=0 for 3 cycles -> z_flag holds 1.
- rst=1 asserted together with we=1, wa=2 -> reg2=0 and z_flag=0.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared sizing and ALU opcode definitions for the register file,
// the ALU and the decoder.
package register_file_pkg;

    localparam int N    = 20;
    localparam int REGS = 16;
    localparam int AW   = $clog2(REGS);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_MUL = 3'b010,
        ALU_DIV = 3'b011,
        ALU_AND = 3'b100,
        ALU_OR  = 3'b101,
        ALU_SHL = 3'b110,
        ALU_SHR = 3'b111
    } alu_op_t;

endpackage

// File: rtl/register_file_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by issue,
// cleared by writeback, and the resulting source-operand stall.
module reg_scoreboard
    import register_file_pkg::*;
#(
    parameter int REGS = register_file_pkg::REGS,
    localparam int AW  = $clog2(REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic          issue,
    input  logic [AW-1:0] issue_rd,
    output logic          stall
);

    logic [REGS-1:0] pending;
    logic            hit1;
    logic            hit2;
    logic            set_en;

    // A source whose producer writes back this cycle is served by bypass.
    always_comb begin
        hit1   = pending[ra1] && (ra1 != '0) && !(we && (wa == ra1));
        hit2   = pending[ra2] && (ra2 != '0) && !(we && (wa == ra2));
        stall  = !rst && (hit1 || hit2);
        set_en = issue && !stall && (issue_rd != '0);
    end

    // Set follows clear so a new producer wins over a retiring one.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (we)
                pending[wa] <= 1'b0;
            if (set_en)
                pending[issue_rd] <= 1'b1;
        end
    end

endmodule

// File: rtl/register_file.sv
// Two-read one-write register file with writeback bypass, zero
// register, pending-write scoreboard and the ALU zero flag.
module register_file
    import register_file_pkg::*;
#(
    parameter int N    = register_file_pkg::N,
    parameter int REGS = register_file_pkg::REGS,
    localparam int AW  = $clog2(REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [N-1:0]  rd1,
    output logic [N-1:0]  rd2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [N-1:0]  wd,
    input  logic          issue,
    input  logic [AW-1:0] issue_rd,
    output logic          stall,
    input  logic          z_we,
    input  logic          z_in,
    output logic          z_flag
);

    logic [N-1:0] mem [REGS];
    logic         wen;

    assign wen = we && !rst && (wa != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++)
                mem[i] <= '0;
        end else if (wen) begin
            mem[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (!rst && ra1 != '0)
            rd1 = (wen && wa == ra1) ? wd : mem[ra1];
        if (!rst && ra2 != '0)
            rd2 = (wen && wa == ra2) ? wd : mem[ra2];
    end

    always_ff @(posedge clk) begin
        if (rst)
            z_flag <= 1'b0;
        else if (z_we)
            z_flag <= z_in;
    end

    reg_scoreboard #(
        .REGS (REGS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .ra1      (ra1),
        .ra2      (ra2),
        .we       (we),
        .wa       (wa),
        .issue    (issue),
        .issue_rd (issue_rd),
        .stall    (stall)
    );

endmodule
